// File: rtl/led_strip_tx.sv
// APA102-style LED strip transmitter: snapshots zone colours and a segment map on start,
// then serialises start frame, one 32-bit frame per LED, and an all-ones end frame.
module led_strip_tx #(
  parameter int NUM_ZONES  = 16,
  parameter int COLOR_W    = 4,
  parameter int NUM_SEG    = 20,
  parameter int LEN_W      = 4,
  parameter int ZONE_IDX_W = 5,
  parameter int HALF_DIV   = 5,
  parameter int END_BITS   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_ZONES*COLOR_W-1:0]    zone_r,
  input  logic [NUM_ZONES*COLOR_W-1:0]    zone_g,
  input  logic [NUM_ZONES*COLOR_W-1:0]    zone_b,
  input  logic [NUM_SEG*ZONE_IDX_W-1:0]   seg_zone,
  input  logic [NUM_SEG*LEN_W-1:0]        seg_len,
  input  logic [4:0]                      brightness,
  input  logic                            order,
  output logic                            busy,
  output logic                            done,
  output logic                            start_drop,
  output logic                            cko_o,
  output logic                            sdo_o
);

  localparam int BIT_MAX  = (END_BITS > 32) ? END_BITS : 32;
  localparam int BIT_W    = $clog2(BIT_MAX);
  localparam int DIV_LAST = 2 * HALF_DIV - 1;
  localparam int DIV_W    = (2 * HALF_DIV > 2) ? $clog2(2 * HALF_DIV) : 1;
  localparam int LED_MAX  = NUM_SEG * ((2 ** LEN_W) - 1);
  localparam int LED_W    = $clog2(LED_MAX + 1);
  localparam int SEG_IW   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START_F = 2'd1,
    LED_F   = 2'd2,
    END_F   = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [DIV_W-1:0]                div_q, div_d;
  logic [BIT_W-1:0]                bit_q, bit_d;
  logic [31:0]                     shreg_q, shreg_d;
  logic [LED_W-1:0]                led_left_q, led_left_d;
  logic [LEN_W-1:0]                rem_q [NUM_SEG];
  logic [LEN_W-1:0]                rem_d [NUM_SEG];
  logic                            done_q, done_d;
  logic                            drop_q, drop_d;
  logic                            load;
  logic                            bit_end;

  logic [NUM_ZONES*COLOR_W-1:0]    zr_q, zg_q, zb_q;
  logic [NUM_SEG*ZONE_IDX_W-1:0]   sz_q;
  logic [4:0]                      bri_q;
  logic                            ord_q;

  logic [LED_W-1:0]                len_sum;
  logic [SEG_IW-1:0]               pick_idx;
  logic [ZONE_IDX_W-1:0]           pick_zone;
  logic [COLOR_W-1:0]              cr, cg, cb;
  logic [7:0]                      r8, g8, b8;
  logic [31:0]                     led_frame;

  // Repeat the channel value MSB-first across 8 bits, truncating the last copy.
  function automatic logic [7:0] expand(input logic [COLOR_W-1:0] v);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = v[COLOR_W-1-(i % COLOR_W)];
    return e;
  endfunction

  // Lowest-indexed segment with LEDs still owed; empty segments cost no time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_idx  = '0;
    pick_zone = '0;
    for (int s = NUM_SEG - 1; s >= 0; s--) begin
      if (rem_q[s] != '0) begin
        pick_idx  = SEG_IW'(s);
        pick_zone = sz_q[s*ZONE_IDX_W +: ZONE_IDX_W];
      end
    end
  end

  // An out-of-range zone index matches no zone and leaves the colours black.
  always_comb begin
    cr = '0;
    cg = '0;
    cb = '0;
    for (int z = 0; z < NUM_ZONES; z++) begin
      if (int'(pick_zone) == z) begin
        cr = zr_q[z*COLOR_W +: COLOR_W];
        cg = zg_q[z*COLOR_W +: COLOR_W];
        cb = zb_q[z*COLOR_W +: COLOR_W];
      end
    end
  end

  assign r8        = expand(cr);
  assign g8        = expand(cg);
  assign b8        = expand(cb);
  assign led_frame = ord_q ? {3'b111, bri_q, g8, r8, b8} : {3'b111, bri_q, b8, g8, r8};

  always_comb begin
    len_sum = '0;
    for (int s = 0; s < NUM_SEG; s++) len_sum = len_sum + LED_W'(seg_len[s*LEN_W +: LEN_W]);
  end

  assign bit_end = (div_q == DIV_W'(DIV_LAST));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    led_left_d = led_left_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    load       = 1'b0;

    if (state_q == IDLE) begin
      if (start) begin
        load       = 1'b1;
        state_d    = START_F;
        div_d      = '0;
        bit_d      = '0;
        shreg_d    = '0;
        led_left_d = len_sum;
        for (int s = 0; s < NUM_SEG; s++) rem_d[s] = seg_len[s*LEN_W +: LEN_W];
      end
    end else begin
      drop_d = start;
      div_d  = bit_end ? '0 : div_q + DIV_W'(1);
      if (bit_end) begin
        unique case (state_q)
          START_F, LED_F: begin
            if (bit_q == BIT_W'(31)) begin
              bit_d = '0;
              if (led_left_q != '0) begin
                state_d         = LED_F;
                shreg_d         = led_frame;
                led_left_d      = led_left_q - LED_W'(1);
                rem_d[pick_idx] = rem_q[pick_idx] - LEN_W'(1);
              end else begin
                state_d = END_F;
                shreg_d = '1;
              end
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shreg_d = {shreg_q[30:0], 1'b0};
            end
          end
          END_F: begin
            if (bit_q == BIT_W'(END_BITS - 1)) begin
              state_d = IDLE;
              bit_d   = '0;
              done_d  = 1'b1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      led_left_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      led_left_q <= led_left_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: the snapshot and per-segment counters are not reset; they are always written on acceptance
  // before being read, so reset would only cost routing.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    if (load) begin
      zr_q  <= zone_r;
      zg_q  <= zone_g;
      zb_q  <= zone_b;
      sz_q  <= seg_zone;
      bri_q <= brightness;
      ord_q <= order;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign start_drop = drop_q;
  assign cko_o      = busy && (div_q >= DIV_W'(HALF_DIV));
  assign sdo_o      = busy && shreg_q[31];

endmodule

// File: tb/tb_led_strip_tx.sv
// Scoreboard bench for led_strip_tx: stimulus pushes the expected bit stream built from a
// behavioural model; a monitor captures sdo_o on rising cko_o and compares on each done.
module tb_led_strip_tx;

  localparam int NUM_ZONES  = 4;
  localparam int COLOR_W    = 4;
  localparam int NUM_SEG    = 2;
  localparam int LEN_W      = 3;
  localparam int ZONE_IDX_W = 3;
  localparam int HALF_DIV   = 2;
  localparam int END_BITS   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [NUM_ZONES*COLOR_W-1:0]  zone_r = '0, zone_g = '0, zone_b = '0;
  logic [NUM_SEG*ZONE_IDX_W-1:0] seg_zone = '0;
  logic [NUM_SEG*LEN_W-1:0]      seg_len = '0;
  logic [4:0]                    brightness = '0;
  logic                          order = 1'b0;
  logic busy, done, start_drop, cko_o, sdo_o;

  always #5 clk = ~clk;

  led_strip_tx #(
    .NUM_ZONES(NUM_ZONES), .COLOR_W(COLOR_W), .NUM_SEG(NUM_SEG), .LEN_W(LEN_W),
    .ZONE_IDX_W(ZONE_IDX_W), .HALF_DIV(HALF_DIV), .END_BITS(END_BITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .zone_r(zone_r), .zone_g(zone_g), .zone_b(zone_b),
    .seg_zone(seg_zone), .seg_len(seg_len), .brightness(brightness), .order(order),
    .busy(busy), .done(done), .start_drop(start_drop), .cko_o(cko_o), .sdo_o(sdo_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_bits[$];
  int exp_len[$];
  int exp_cyc[$];
  int n_pushed = 0;
  int n_done = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] expand8(input logic [COLOR_W-1:0] v);
    logic [8*COLOR_W-1:0] rep;
    rep = {8{v}};
    return rep[8*COLOR_W-1 -: 8];
  endfunction

  function automatic logic [31:0] led_word(input int zi);
    logic [7:0] r, g, b;
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (zi < NUM_ZONES) begin
      r = expand8(zone_r[zi*COLOR_W +: COLOR_W]);
      g = expand8(zone_g[zi*COLOR_W +: COLOR_W]);
      b = expand8(zone_b[zi*COLOR_W +: COLOR_W]);
    end
    return order ? {3'b111, brightness, g, r, b} : {3'b111, brightness, b, g, r};
  endfunction

  task automatic push_expect();
    int n;
    int len;
    int zi;
    logic [31:0] w;
    n = 0;
    repeat (32) exp_bits.push_back(1'b0);
    for (int s = 0; s < NUM_SEG; s++) begin
      len = int'(seg_len[s*LEN_W +: LEN_W]);
      zi  = int'(seg_zone[s*ZONE_IDX_W +: ZONE_IDX_W]);
      w   = led_word(zi);
      for (int k = 0; k < len; k++) begin
        for (int b = 31; b >= 0; b--) exp_bits.push_back(w[b]);
        n++;
      end
    end
    repeat (END_BITS) exp_bits.push_back(1'b1);
    exp_len.push_back(32 + 32*n + END_BITS);
    exp_cyc.push_back((32 + 32*n + END_BITS) * 2 * HALF_DIV);
    n_pushed++;
  endtask

  // ---------------- monitor ----------------
  bit got[$];
  int cyc = 0, start_cyc = 0, run = 0, bad_runs = 0, bad_sdo = 0, idle_bad = 0;
  bit p_busy = 1'b0, p_cko = 1'b0, p_sdo = 1'b0;

  always @(negedge clk) begin : monitor
    int n, ec;
    logic [31:0] gw, ew;
    if (mon_en) begin
      cyc++;
      if (busy && !p_busy) begin
        got.delete();
        start_cyc = cyc;
        run = 0; bad_runs = 0; bad_sdo = 0;
      end
      if (busy) begin
        if (p_busy && (cko_o != p_cko)) begin
          if (run != HALF_DIV) bad_runs++;
          run = 1;
        end else begin
          run++;
        end
        if (p_busy && (sdo_o != p_sdo) && !(p_cko && !cko_o)) bad_sdo++;
        if (cko_o && !p_cko) got.push_back(sdo_o);
      end else if (cko_o || sdo_o) begin
        idle_bad++;
      end
      if (done) begin
        n_done++;
        if (run != HALF_DIV) bad_runs++;
        check("expect_pending", longint'(exp_len.size() != 0), 1);
        if (exp_len.size() != 0) begin
          n  = exp_len.pop_front();
          ec = exp_cyc.pop_front();
          check("bit_count", got.size(), n);
          check("duration", cyc - start_cyc, ec);
          for (int i = 0; i < n; i += 32) begin
            gw = '0; ew = '0;
            for (int j = i; j < i + 32 && j < n; j++) begin
              gw = {gw[30:0], (j < got.size()) ? got[j] : 1'b0};
              ew = {ew[30:0], exp_bits.pop_front()};
            end
            check($sformatf("word%0d", i / 32), gw, ew);
          end
          check("cko_half_period", bad_runs, 0);
          check("sdo_edge", bad_sdo, 0);
        end
        got.delete();
      end else if (p_busy && !busy) begin
        got.delete();
      end
      p_busy = busy;
      p_cko  = cko_o;
      p_sdo  = sdo_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_zone(input int z, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    zone_r[z*COLOR_W +: COLOR_W] = r;
    zone_g[z*COLOR_W +: COLOR_W] = g;
    zone_b[z*COLOR_W +: COLOR_W] = b;
  endtask

  // Called at a negedge: raises start for one cycle and records the expected frame.
  task automatic send(input bit expect_it);
    start = 1'b1;
    if (expect_it) push_expect();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", done, 1);
  endtask

  initial begin
    // 1: reset held 3 cycles with start pulses inside it
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", start_drop, 0);
    check("rst_cko", cko_o, 0);
    check("rst_sdo", sdo_o, 0);
    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    check("no_frame_after_reset", busy, 0);

    // 2: two LEDs from zone 1, order B,G,R
    set_zone(1, 4'hA, 4'h5, 4'h3);
    seg_len    = {3'd2, 3'd0};
    seg_zone   = {3'd1, 3'd0};
    brightness = 5'h1F;
    order      = 1'b0;
    send(1'b1);
    wait_done(2000);

    // 3: same with order G,R,B
    @(negedge clk);
    order = 1'b1;
    send(1'b1);
    wait_done(2000);

    // 4A: invalid zone index
    @(negedge clk);
    seg_len    = {3'd0, 3'd1};
    seg_zone   = {3'd0, 3'd6};
    brightness = 5'h03;
    order      = 1'b0;
    send(1'b1);
    wait_done(2000);

    // 4B: no LEDs at all
    @(negedge clk);
    seg_len = '0;
    send(1'b1);
    wait_done(2000);

    // 5A: start while busy is dropped; input changes do not leak into the frame
    @(negedge clk);
    set_zone(0, 4'h1, 4'h2, 4'h4);
    set_zone(2, 4'hC, 4'h9, 4'hE);
    seg_len  = {3'd1, 3'd2};
    seg_zone = {3'd2, 3'd0};
    send(1'b1);
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drop_pulse", start_drop, 1);
    zone_r   = ~zone_r;
    seg_len  = {3'd7, 3'd7};
    order    = 1'b1;
    @(negedge clk);
    check("drop_single_cycle", start_drop, 0);
    check("busy_after_drop", busy, 1);
    wait_done(3000);

    // 5B: start in the done cycle is accepted
    seg_len    = {3'd1, 3'd0};
    seg_zone   = {3'd3, 3'd0};
    set_zone(3, 4'h7, 4'hB, 4'hD);
    brightness = 5'h0A;
    order      = 1'b0;
    send(1'b1);
    wait_done(3000);
    send(1'b1);
    check("busy_back_to_back", busy, 1);
    wait_done(3000);

    // 6: reset mid-frame aborts silently, then a clean frame follows
    @(negedge clk);
    seg_len = {3'd2, 3'd2};
    send(1'b0);
    repeat (180) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cko", cko_o, 0);
    check("abort_sdo", sdo_o, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_idle", busy, 0);
    send(1'b1);
    wait_done(3000);

    // Randomised frames
    for (int it = 0; it < 8; it++) begin
      @(negedge clk);
      zone_r     = (NUM_ZONES*COLOR_W)'($urandom);
      zone_g     = (NUM_ZONES*COLOR_W)'($urandom);
      zone_b     = (NUM_ZONES*COLOR_W)'($urandom);
      seg_zone   = (NUM_SEG*ZONE_IDX_W)'($urandom);
      seg_len    = (NUM_SEG*LEN_W)'($urandom);
      brightness = 5'($urandom);
      order      = 1'($urandom);
      send(1'b1);
      wait_done(3000);
    end

    repeat (10) @(negedge clk);
    check("queue_drained", exp_len.size(), 0);
    check("done_count", n_done, n_pushed);
    check("idle_outputs", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
Parametrised single-clock successor to the fixed 47-LED serial LED sender. It snapshots per-zone RGB colours and a segment map on `start`, then serialises an APA102-style stream on `cko_o`/`sdo_o`. The stream is a start frame, one 32-bit frame per LED and an end frame. Zone count, colour width, segment count, clock divide, end-frame length and colour order are all configurable; the design needs no FIFO and no CDC.

Parameters:
NUM_ZONES, 16, number of colour zones
COLOR_W, 4, bits per colour channel per zone; legal range 1..8
NUM_SEG, 20, number of strip segments
LEN_W, 4, width of each segment length field
ZONE_IDX_W, 5, width of each segment zone-index field
HALF_DIV, 5, clk cycles per cko half period; must be ≥1
END_BITS, 32, number of 1-bits in the end frame; must be ≥1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
start  in  1  single-cycle request to send one frame
zone_r  in  NUM_ZONES*COLOR_W  R value of each zone; zone z occupies bits [z*COLOR_W +: COLOR_W]
zone_g  in  NUM_ZONES*COLOR_W  G value of each zone
zone_b  in  NUM_ZONES*COLOR_W  B value of each zone
seg_zone  in  NUM_SEG*ZONE_IDX_W  zone index for each segment
seg_len  in  NUM_SEG*LEN_W  LED count for each segment
brightness  in  5  global brightness field
order  in  1  colour byte order: 0 = B,G,R; 1 = G,R,B
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse when a frame completes
start_drop  out  1  one-cycle pulse when a start is ignored
cko_o  out  1  serial clock
sdo_o  out  1  serial data

Behaviour:
- Reset: a synchronous `rst` forces busy=0, done=0, start_drop=0, cko_o=0, sdo_o=0 and state IDLE at the next edge. A reset mid-frame aborts the frame silently; no done pulse is generated.
- States: IDLE → START_F → LED_F → END_F → IDLE.
- Start acceptance: `start` is accepted only when busy=0, which includes the cycle in which done is high.
  - On acceptance, zone_*, seg_*, brightness and order are latched. Input changes after that point do not affect the frame in progress.
  - busy=1 from the next cycle.
- Start while busy: the request is ignored and start_drop pulses for one cycle. The frame in progress continues unaffected.
- Bit timing:
  - Each bit lasts 2*HALF_DIV clk cycles. For the first HALF_DIV cycles cko_o=0; for the last HALF_DIV cycles cko_o=1.
  - sdo_o changes only on the cycle in which cko_o goes low.
  - The first bit begins the cycle after acceptance.
  - Bits are sent MSB first.
- START_F: 32 zero bits.
- LED_F: one frame per LED.
  - Segments are walked in order 0..NUM_SEG-1, and segment s emits seg_len[s] frames. Segments with length 0 are skipped without consuming any time.
  - Frame layout: {3'b111, brightness, C0, C1, C2}, where (C0,C1,C2) = (B,G,R) when order=0 and (G,R,B) when order=1.
- Colour expansion to 8 bits: the COLOR_W value is repeated MSB-first to fill 8 bits, truncating the final copy (e.g. 4'hA → 8'hAA, 3'b101 → 8'hB6). When COLOR_W=8, the value passes through unchanged.
- Invalid zone index: if seg_zone ≥ NUM_ZONES, the segment's LEDs are sent with C0=C1=C2=8'h00 and the brightness field retained.
- END_F: END_BITS one-bits.
- Completion: in the cycle after the last high half of the final end bit, done=1, busy=0, cko_o=0, sdo_o=0 and the state returns to IDLE.
- Total-length rule: total LEDs N = Σ seg_len. If N=0, the block sends only START_F and END_F. Frame duration is (32 + 32N + END_BITS)*2*HALF_DIV cycles, measured from acceptance+1 to done.
- Counters:
  - The bit counter is sized to cover max(32, END_BITS).
  - The LED counter is sized to cover NUM_SEG*(2^LEN_W − 1), so no wrap is possible.
- Idle outputs: cko_o=0 and sdo_o=0.

Test Plan:
Common bench parameters: NUM_ZONES=4, COLOR_W=4, NUM_SEG=2, LEN_W=3, ZONE_IDX_W=3, HALF_DIV=2, END_BITS=8.
1. Reset: hold rst for 3 cycles, pulsing start during reset → busy/done/start_drop/cko_o/sdo_o all 0 and no frame is emitted.
2. seg_len={0,2}, seg1 zone=1, zone1 R=A G=5 B=3, brightness=1F, order=0 → stream is 32×0, then 0xFF3355AA twice, then 8×1. done arrives exactly 416 cycles after acceptance+1, and cko_o toggles every 2 cycles.
3. Same stimulus with order=1 → LED frames are 0xFF55AA33.
4. Case A: seg0 len=1 with zone=6 (invalid), brightness=03 → frame 0xE3000000. Case B: all lengths 0 → 40 bits total, done after 160 cycles.
5. Case A: pulse start mid-LED_F → start_drop pulses, stream is unchanged, and changing zone_r mid-frame has no effect. Case B: start in the done cycle → accepted, busy stays 1 and the next start frame begins the following cycle.
6. Assert rst for 1 cycle during an LED frame → outputs are 0 and the block is IDLE next cycle with no done pulse; a subsequent start produces a complete, correct frame.
